// File: rtl/spi_pkg.sv
// Shared SPI definitions for the mode-1 receive path.
// Holds the mode-1 clock polarity/phase constants, the receiver state
// encoding, the minimum oversampling ratio and a saturating counter helper.
package spi_pkg;

  localparam logic SPI_MODE1_CPOL = 1'b0;
  localparam logic SPI_MODE1_CPHA = 1'b1;

  // The system clock must run at least this many times faster than SCLK
  // for the 3-cycle synchronizer path to see every SCLK level.
  localparam int MIN_OVERSAMPLE = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer followed by one history flop for an asynchronous
// single-bit input, with edge detection between the synchronized level and
// its one-cycle-old copy.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input line
//   level      : synchronized level (second synchronizer stage)
//   prev       : synchronized level delayed by one cycle (history stage)
//   rise, fall : single-cycle edge indications derived from level/prev
module spi_in_sync
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic prev,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic hist_r;

  // Synchronizer chain plus history stage, reset to the line's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
      hist_r <= RESET_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      hist_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign prev  = hist_r;
  assign rise  = sync_r & ~hist_r;
  assign fall  = ~sync_r & hist_r;

endmodule

// File: rtl/spi_slave_rx_mode1.sv
// SPI mode-1 (CPOL=0, CPHA=1) slave receiver. The SPI lines are
// oversampled on In_clk; MOSI is captured on each synchronized SCLK falling
// edge while CS_n is low, and each completed word is presented with a
// one-cycle valid pulse. Frames that end mid-word raise a one-cycle error.
// Ports:
//   In_clk, In_rst_n   : system clock, asynchronous active-low reset
//   In_spi_cs_n        : chip select (active low, asynchronous)
//   In_spi_sclk        : SPI clock (idle low, asynchronous)
//   In_spi_mosi        : serial data from master (asynchronous)
//   Out_rx_data        : last completed word, held until the next one
//   Out_rx_valid       : one-cycle pulse when Out_rx_data updates
//   Out_frame_err      : one-cycle pulse when CS_n rises on a partial word
//   Out_busy           : high while synchronized CS_n is low
//   Out_word_cnt       : words completed in the current frame (saturating)
module spi_slave_rx_mode1
  import spi_pkg::*;
#(
  parameter int REF_CLK    = 50_000_000,
  parameter int SPI_SCLK   = 50_000,
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  In_clk,
  input  logic                  In_rst_n,
  input  logic                  In_spi_cs_n,
  input  logic                  In_spi_sclk,
  input  logic                  In_spi_mosi,
  output logic [DATA_WIDTH-1:0] Out_rx_data,
  output logic                  Out_rx_valid,
  output logic                  Out_frame_err,
  output logic                  Out_busy,
  output logic [15:0]           Out_word_cnt
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic cs_level_s, cs_prev_s, cs_rise_s, cs_fall_s;
  logic sclk_level_s, sclk_prev_s, sclk_rise_s, sclk_fall_s;
  logic mosi_level_s, mosi_prev_s, mosi_rise_s, mosi_fall_s;

  spi_in_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(In_clk), .rst_n(In_rst_n), .din(In_spi_cs_n),
    .level(cs_level_s), .prev(cs_prev_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_in_sync #(.RESET_VAL(SPI_MODE1_CPOL)) u_sync_sclk (
    .clk(In_clk), .rst_n(In_rst_n), .din(In_spi_sclk),
    .level(sclk_level_s), .prev(sclk_prev_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_in_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(In_clk), .rst_n(In_rst_n), .din(In_spi_mosi),
    .level(mosi_level_s), .prev(mosi_prev_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  // Edge outputs not needed by the mode-1 receiver, and the clock-ratio
  // configuration that only documents the oversampling requirement.
  logic sync_unused_s;
  logic cfg_unused_s;
  assign sync_unused_s = ^{cs_prev_s, cs_fall_s, sclk_level_s, sclk_prev_s, sclk_rise_s,
                           mosi_prev_s, mosi_rise_s, mosi_fall_s};
  assign cfg_unused_s  = ((REF_CLK / SPI_SCLK) >= MIN_OVERSAMPLE) && (SPI_MODE1_CPHA == 1'b1);

  spi_state_e            state_r, state_next_s;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic [DATA_WIDTH-1:0] shift_r, shift_next_s;
  logic [DATA_WIDTH-1:0] rx_data_r;
  logic                  rx_valid_r, frame_err_r, busy_r;
  logic [15:0]           word_cnt_r;
  logic                  enter_active_s, shift_en_s, word_done_s, frame_err_s;

  // Shift register value after accepting the current synchronized MOSI bit.
  always_comb begin
    shift_next_s = shift_r;
    if (MSB_FIRST) begin
      shift_next_s = {shift_r[DATA_WIDTH-2:0], mosi_level_s};
    end else begin
      shift_next_s = {mosi_level_s, shift_r[DATA_WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge In_clk or negedge In_rst_n) begin
    if (!In_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next_s   = state_r;
    enter_active_s = 1'b0;
    shift_en_s     = 1'b0;
    word_done_s    = 1'b0;
    frame_err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!cs_level_s) begin
          state_next_s   = ACTIVE;
          enter_active_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACTIVE: begin
        if (sclk_fall_s) begin
          shift_en_s  = 1'b1;
          word_done_s = (bit_cnt_r == LAST_BIT);
        end else begin
          shift_en_s  = 1'b0;
          word_done_s = 1'b0;
        end
        // A final edge coinciding with CS rise still completes the word.
        if (cs_rise_s) begin
          state_next_s = IDLE;
          frame_err_s  = (bit_cnt_r != {CNT_W{1'b0}}) && !word_done_s;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Bit counter, shift register and registered outputs.
  always_ff @(posedge In_clk or negedge In_rst_n) begin
    if (!In_rst_n) begin
      bit_cnt_r   <= {CNT_W{1'b0}};
      shift_r     <= {DATA_WIDTH{1'b0}};
      rx_data_r   <= {DATA_WIDTH{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
      word_cnt_r  <= 16'd0;
    end else begin
      rx_valid_r  <= word_done_s;
      frame_err_r <= frame_err_s;
      busy_r      <= ~cs_level_s;
      if (enter_active_s) begin
        bit_cnt_r  <= {CNT_W{1'b0}};
        shift_r    <= {DATA_WIDTH{1'b0}};
        word_cnt_r <= 16'd0;
      end else if (shift_en_s) begin
        shift_r <= shift_next_s;
        if (word_done_s) begin
          bit_cnt_r  <= {CNT_W{1'b0}};
          rx_data_r  <= shift_next_s;
          word_cnt_r <= sat_inc16(word_cnt_r);
        end else begin
          bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign Out_rx_data   = rx_data_r;
  assign Out_rx_valid  = rx_valid_r;
  assign Out_frame_err = frame_err_r;
  assign Out_busy      = busy_r;
  assign Out_word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_spi_slave_rx_mode1.sv
`timescale 1ns/1ps
module tb_spi_slave_rx_mode1;

  localparam int HALF = 10000;  // half SCLK period in ns (50 kHz)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;

  always #10 clk = ~clk;

  logic [7:0]  data_m, data_l;
  logic        valid_m, valid_l, err_m, err_l, busy_m, busy_l;
  logic [15:0] cnt_m, cnt_l;

  spi_slave_rx_mode1 #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .In_clk(clk), .In_rst_n(rst_n), .In_spi_cs_n(cs_n), .In_spi_sclk(sclk),
    .In_spi_mosi(mosi), .Out_rx_data(data_m), .Out_rx_valid(valid_m),
    .Out_frame_err(err_m), .Out_busy(busy_m), .Out_word_cnt(cnt_m)
  );

  spi_slave_rx_mode1 #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .In_clk(clk), .In_rst_n(rst_n), .In_spi_cs_n(cs_n), .In_spi_sclk(sclk),
    .In_spi_mosi(mosi), .Out_rx_data(data_l), .Out_rx_valid(valid_l),
    .Out_frame_err(err_l), .Out_busy(busy_l), .Out_word_cnt(cnt_l)
  );

  typedef struct packed { logic [7:0] d; logic [15:0] c; } obs_t;
  typedef struct packed { logic [7:0] dm; logic [7:0] dl; logic [15:0] c; } exp_t;

  exp_t  exp_q[$];
  obs_t  obs_m[$];
  obs_t  obs_l[$];
  time   vt_m[$];
  int    err_pulses_m = 0;
  int    err_pulses_l = 0;
  int    wide_pulse = 0;
  logic  pv_m = 1'b0, pv_l = 1'b0, pe_m = 1'b0, pe_l = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  // Output monitor: records valid words and error pulses, flags pulses
  // that last longer than one cycle.
  always @(negedge clk) begin
    if (valid_m) begin
      obs_m.push_back({data_m, cnt_m});
      vt_m.push_back($time);
    end
    if (valid_l) obs_l.push_back({data_l, cnt_l});
    if (err_m) err_pulses_m <= err_pulses_m + 1;
    if (err_l) err_pulses_l <= err_pulses_l + 1;
    if ((valid_m && pv_m) || (valid_l && pv_l) || (err_m && pe_m) || (err_l && pe_l))
      wide_pulse <= wide_pulse + 1;
    pv_m <= valid_m;
    pv_l <= valid_l;
    pe_m <= err_m;
    pe_l <= err_l;
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic expect_word(input logic [7:0] w, input logic [15:0] c);
    exp_q.push_back({w, rev8(w), c});
  endtask

  task automatic cs_start();
    @(negedge clk);
    cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_end();
    cs_n = 1'b1;
    #2000;
  endtask

  // Master mode-1 shifting: data changes on rising SCLK, slave samples on falling.
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      mosi = w[7-i];
      #HALF;
      sclk = 1'b0;
      #HALF;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #201;
    n_tests++;
    if ({data_m, valid_m, err_m, busy_m, cnt_m, data_l, valid_l, err_l, busy_l, cnt_l} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: msb %h/%b/%b/%b/%0d lsb %h/%b/%b/%b/%0d, required all 0",
               data_m, valid_m, err_m, busy_m, cnt_m, data_l, valid_l, err_l, busy_l, cnt_l);
    end
    rst_n = 1'b1;
    #100000;
    n_tests++;
    if (obs_m.size() != 0 || obs_l.size() != 0 ||
        {data_m, err_m, busy_m, cnt_m, data_l, err_l, busy_l, cnt_l} !== '0) begin
      n_fail++;
      $display("FAIL idle_quiet: valids %0d/%0d data %h/%h busy %b/%b, required none and 0",
               obs_m.size(), obs_l.size(), data_m, data_l, busy_m, busy_l);
    end
  endtask

  task automatic test_single();
    exp_t e; obs_t om, ol;
    expect_word(8'hA5, 16'd1);
    cs_start();
    n_tests++;
    if (busy_m !== 1'b1 || busy_l !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_frame: got %b/%b, required 1", busy_m, busy_l);
    end
    send_bits(8'hA5, 8);
    cs_end();
    n_tests++;
    if (obs_m.size() != exp_q.size() || obs_l.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single_count: valids %0d/%0d, required %0d", obs_m.size(), obs_l.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_m.size() > 0 && obs_l.size() > 0) begin
      e = exp_q.pop_front(); om = obs_m.pop_front(); ol = obs_l.pop_front();
      n_tests++;
      if (om !== {e.dm, e.c} || ol !== {e.dl, e.c}) begin
        n_fail++;
        $display("FAIL single_word: got %h/%0d %h/%0d, required %h %h cnt %0d", om.d, om.c, ol.d, ol.c, e.dm, e.dl, e.c);
      end
    end
    n_tests++;
    if (busy_m !== 1'b0 || err_pulses_m != 0 || err_pulses_l != 0 || cnt_m !== 16'd1) begin
      n_fail++;
      $display("FAIL single_end: busy %b errs %0d/%0d cnt %0d, required 0 0/0 1", busy_m, err_pulses_m, err_pulses_l, cnt_m);
    end
    exp_q.delete(); obs_m.delete(); obs_l.delete(); vt_m.delete();
  endtask

  task automatic test_back_to_back();
    exp_t e; obs_t om, ol;
    expect_word(8'h3C, 16'd1);
    expect_word(8'hC3, 16'd2);
    cs_start();
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    cs_end();
    n_tests++;
    if (obs_m.size() != exp_q.size() || obs_l.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count: valids %0d/%0d, required %0d", obs_m.size(), obs_l.size(), exp_q.size());
    end
    n_tests++;
    if (vt_m.size() != 2 || (vt_m.size() == 2 && (vt_m[1] - vt_m[0]) != 160000)) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0d pulses, required 2 pulses 160000 ns apart", vt_m.size());
    end
    while (exp_q.size() > 0 && obs_m.size() > 0 && obs_l.size() > 0) begin
      e = exp_q.pop_front(); om = obs_m.pop_front(); ol = obs_l.pop_front();
      n_tests++;
      if (om !== {e.dm, e.c} || ol !== {e.dl, e.c}) begin
        n_fail++;
        $display("FAIL b2b_word: got %h/%0d %h/%0d, required %h %h cnt %0d", om.d, om.c, ol.d, ol.c, e.dm, e.dl, e.c);
      end
    end
    exp_q.delete(); obs_m.delete(); obs_l.delete(); vt_m.delete();
  endtask

  task automatic test_abort();
    exp_t e; obs_t om, ol;
    cs_start();
    send_bits(8'hFF, 5);
    cs_end();
    n_tests++;
    if (err_pulses_m != 1 || err_pulses_l != 1 || obs_m.size() != 0 || obs_l.size() != 0) begin
      n_fail++;
      $display("FAIL abort_err: errs %0d/%0d valids %0d/%0d, required 1/1 and 0/0",
               err_pulses_m, err_pulses_l, obs_m.size(), obs_l.size());
    end
    n_tests++;
    if (data_m !== 8'hC3 || data_l !== 8'hC3) begin
      n_fail++;
      $display("FAIL abort_hold: data %h/%h, required c3/c3", data_m, data_l);
    end
    expect_word(8'h5A, 16'd1);
    cs_start();
    send_bits(8'h5A, 8);
    cs_end();
    n_tests++;
    if (obs_m.size() != exp_q.size() || obs_l.size() != exp_q.size() || err_pulses_m != 1) begin
      n_fail++;
      $display("FAIL after_abort_count: valids %0d/%0d errs %0d, required %0d and 1",
               obs_m.size(), obs_l.size(), err_pulses_m, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_m.size() > 0 && obs_l.size() > 0) begin
      e = exp_q.pop_front(); om = obs_m.pop_front(); ol = obs_l.pop_front();
      n_tests++;
      if (om !== {e.dm, e.c} || ol !== {e.dl, e.c}) begin
        n_fail++;
        $display("FAIL after_abort_word: got %h/%0d %h/%0d, required %h %h cnt %0d", om.d, om.c, ol.d, ol.c, e.dm, e.dl, e.c);
      end
    end
    exp_q.delete(); obs_m.delete(); obs_l.delete(); vt_m.delete();
  endtask

  task automatic test_bit_order();
    cs_start();
    send_bits(8'h01, 8);
    cs_end();
    n_tests++;
    if (obs_m.size() != 1 || obs_l.size() != 1) begin
      n_fail++;
      $display("FAIL order_count: valids %0d/%0d, required 1/1", obs_m.size(), obs_l.size());
    end else if (obs_m[0].d !== 8'h01 || obs_l[0].d !== 8'h80) begin
      n_fail++;
      $display("FAIL order_word: msb %h lsb %h, required 01 80", obs_m[0].d, obs_l[0].d);
    end
    exp_q.delete(); obs_m.delete(); obs_l.delete(); vt_m.delete();
  endtask

  task automatic test_reset_midframe();
    exp_t e; obs_t om, ol;
    cs_start();
    send_bits(8'hE0, 3);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({data_m, valid_m, err_m, busy_m, cnt_m, data_l, valid_l, err_l, busy_l, cnt_l} !== '0) begin
      n_fail++;
      $display("FAIL midreset_state: data %h/%h busy %b/%b cnt %0d/%0d, required all 0",
               data_m, data_l, busy_m, busy_l, cnt_m, cnt_l);
    end
    #200;
    rst_n = 1'b1;
    #HALF;
    cs_end();
    n_tests++;
    if (err_pulses_m != 1 || err_pulses_l != 1 || obs_m.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: errs %0d/%0d valids %0d, required 1/1 and 0",
               err_pulses_m, err_pulses_l, obs_m.size());
    end
    expect_word(8'h96, 16'd1);
    cs_start();
    send_bits(8'h96, 8);
    cs_end();
    n_tests++;
    if (obs_m.size() != exp_q.size() || obs_l.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midreset_count: valids %0d/%0d, required %0d", obs_m.size(), obs_l.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_m.size() > 0 && obs_l.size() > 0) begin
      e = exp_q.pop_front(); om = obs_m.pop_front(); ol = obs_l.pop_front();
      n_tests++;
      if (om !== {e.dm, e.c} || ol !== {e.dl, e.c}) begin
        n_fail++;
        $display("FAIL midreset_word: got %h/%0d %h/%0d, required %h %h cnt %0d", om.d, om.c, ol.d, ol.c, e.dm, e.dl, e.c);
      end
    end
    exp_q.delete(); obs_m.delete(); obs_l.delete(); vt_m.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_bit_order();
    test_reset_midframe();
    n_tests++;
    if (wide_pulse != 0) begin
      n_fail++;
      $display("FAIL pulse_width: %0d multi-cycle pulses, required 0", wide_pulse);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx_mode1.md
Name: spi_slave_rx_mode1

Overview:
SPI slave receiver for SPI mode 1 (CPOL=0, CPHA=1). It is the receiving end of the mode-1 master transmitter and shares its CS_n/SCLK/MOSI wiring. It oversamples the external SPI lines on the system clock, samples MOSI on SCLK falling edges while CS_n is low, and emits each received word as a one-cycle valid pulse. It also flags frames aborted mid-word.

Parameters:
REF_CLK, 50_000_000, system clock frequency in Hz (documentation/assertion only; REF_CLK >= 8*SPI_SCLK required).
SPI_SCLK, 50_000, expected SCLK frequency in Hz (documentation/assertion only).
DATA_WIDTH, 8, bits per word (2..32).
MSB_FIRST, 1, 1 = first received bit is placed at the MSB; 0 = first bit is placed at the LSB.

Ports:
In_clk  input  1  system clock, all logic on its rising edge.
In_rst_n  input  1  asynchronous active-low reset.
In_spi_cs_n  input  1  chip select from master, active low, asynchronous to In_clk.
In_spi_sclk  input  1  SPI clock from master, idle low, asynchronous.
In_spi_mosi  input  1  serial data from master, asynchronous.
Out_rx_data  output  DATA_WIDTH  last completed word; holds until the next word completes.
Out_rx_valid  output  1  one-cycle pulse when Out_rx_data updates.
Out_frame_err  output  1  one-cycle pulse when CS_n rises with a partial word.
Out_busy  output  1  high while the synchronized CS_n is low.
Out_word_cnt  output  16  words completed in the current CS frame; saturates at 0xFFFF.

Behaviour:
- Clock/reset: one clock In_clk. Reset is asynchronous and active-low on In_rst_n.
- Reset values:
  - all outputs 0.
  - synchronizer stages: cs_n=1, sclk=0, mosi=0.
  - bit counter 0, shift register 0, state IDLE.
- Synchronization: each SPI input passes through a 2-FF synchronizer plus one history FF.
  - Falling edge detect: sclk_d1=1 and sclk_d0=0.
  - CS rise detect: cs_d1=0 and cs_d0=1.
  - Input-to-decision latency is 3 In_clk cycles.
- State machine:
  - IDLE: wait for synchronized cs_n=0, then go to ACTIVE. Bit counter and shift register are cleared on entry.
  - ACTIVE: on each SCLK falling edge, shift synchronized MOSI into the shift register and increment the bit counter.
    - MSB_FIRST=1: shift left, new bit in at the LSB.
    - MSB_FIRST=0: shift right, new bit in at the MSB.
  - Word completion: when the bit counter reaches DATA_WIDTH-1 and a falling edge occurs, on the next cycle:
    - Out_rx_data = the completed word; Out_rx_valid = 1 for exactly one cycle.
    - Out_word_cnt increments; the bit counter wraps to 0.
    - Back-to-back words in one frame need no gap.
  - ACTIVE -> IDLE on synchronized CS rise.
    - Bit counter != 0: Out_frame_err pulses one cycle, the partial word is discarded, Out_rx_data is unchanged.
    - Bit counter == 0: clean end, no pulse.
- Rising SCLK edges are ignored; the master shifts on them.
- SCLK edges while cs_n is high are ignored; the counters do not move.
- Simultaneous last falling edge and CS rise in the same cycle: the word completes (valid pulse), no frame_err.
- Out_word_cnt clears on entry to ACTIVE and holds its value after CS rises until the next frame.
- Reset mid-frame: everything returns to reset values immediately. If CS is still low at reset release, the receiver enters ACTIVE and counts bits from the next falling edge. That word may be misaligned; accepted behaviour.
- Out_busy equals the inverse of synchronized cs_n.

Decomposition:
- Shared package spi_pkg holds:
  - mode constants: SPI_MODE1_CPOL=0, SPI_MODE1_CPHA=1.
  - the state encoding: IDLE=0, ACTIVE=1.
  - the MIN_OVERSAMPLE=8 constant.
- One sub-module, spi_in_sync: a parameterizable 2-FF synchronizer with history FF, giving rise/fall outputs. Instantiate it three times (cs_n, sclk, mosi).
- Bit counter, shift register and FSM stay in the top.

Test Plan:
- Reset then idle: In_rst_n low 201 ns, lines idle (cs_n=1, sclk=0) -> all outputs 0, no valid for 100 us.
- Single word: 50 MHz clk, 50 kHz SCLK, master sends 0xA5 MSB-first -> one Out_rx_valid pulse, Out_rx_data=0xA5, Out_word_cnt=1, no frame_err.
- Back-to-back: 0x3C then 0xC3 in one CS frame, no SCLK gap -> two valid pulses 8 SCLK periods apart, data 0x3C then 0xC3, Out_word_cnt=2.
- Abort: CS rises after 5 bits of 0xFF -> Out_frame_err pulses once, no valid, Out_rx_data keeps its prior value. Next frame 0x5A is received correctly.
- Bit order: MSB_FIRST=0, master sends 0x01 MSB-first -> Out_rx_data=0x80.
- Reset mid-frame: assert In_rst_n low after 3 bits with CS held low, then release -> outputs 0 immediately. Next full frame with CS re-asserted, sending 0x96 -> Out_rx_data=0x96.
